// File: rtl/cache_way_controller_if.sv
// CPU request/response and physical-memory handshake of the cache way controller.
// The controller attaches through the slave modport; the CPU/memory side uses master.
interface cache_way_controller_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;
  logic pmem_addr_sel;

  modport slave (
    input  mem_read, mem_write, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel
  );

  modport master (
    output mem_read, mem_write, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel
  );
endinterface

// File: rtl/cache_way_controller.sv
// Sequencing FSM for the 8-way write-back cache: hit/miss decision, victim choice,
// write-back and line-fill handshakes, LRU update strobe and saturating perf counters.
module cache_way_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  cache_way_controller_if.slave  bus,
  input  logic [7:0]             hit,
  input  logic [7:0]             valid,
  input  logic [7:0]             dirty,
  input  logic [2:0]             lru_way,
  output logic                   lru_update,
  output logic [7:0]             lru_hit,
  output logic [7:0]             way_load,
  output logic                   data_sel,
  output logic                   dirty_set,
  output logic                   dirty_clear,
  output logic [2:0]             victim_way,
  output logic                   multi_hit_err,
  output logic [CNT_WIDTH-1:0]   hit_count,
  output logic [CNT_WIDTH-1:0]   miss_count,
  output logic [CNT_WIDTH-1:0]   wb_count
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [2:0]             victim_way_q, victim_way_d;
  logic                   retry_q, retry_d;
  logic                   multi_hit_err_q, multi_hit_err_d;
  logic [CNT_WIDTH-1:0]   hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0]   miss_count_q, miss_count_d;
  logic [CNT_WIDTH-1:0]   wb_count_q, wb_count_d;

  logic                   request;
  logic [7:0]             hit_first;
  logic                   multi_hit;
  logic [2:0]             victim_sel;
  logic [7:0]             victim_onehot;

  assign request       = bus.mem_read | bus.mem_write;
  assign hit_first     = hit & (~hit + 8'd1);
  assign multi_hit     = (hit & (hit - 8'd1)) != 8'd0;
  assign victim_onehot = 8'd1 << victim_way_q;

  // Lowest-index invalid way wins; a full set falls back to the LRU way.
  always_comb begin
    victim_sel = lru_way;
    for (int i = 7; i >= 0; i--) begin
      if (!valid[i]) victim_sel = 3'(i);
    end
  end

  always_comb begin
    state_d           = state_q;
    victim_way_d      = victim_way_q;
    retry_d           = retry_q;
    multi_hit_err_d   = multi_hit_err_q;
    hit_count_d       = hit_count_q;
    miss_count_d      = miss_count_q;
    wb_count_d        = wb_count_q;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    lru_update        = 1'b0;
    lru_hit           = 8'd0;
    way_load          = 8'd0;
    data_sel          = 1'b0;
    dirty_set         = 1'b0;
    dirty_clear       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (request) begin
          state_d = CHECK;
          retry_d = 1'b0;
        end
      end
      CHECK: begin
        if (hit != 8'd0) begin
          bus.mem_resp = 1'b1;
          lru_update   = 1'b1;
          lru_hit      = hit_first;
          if (bus.mem_write) begin
            way_load  = hit_first;
            dirty_set = 1'b1;
          end
          if (multi_hit) multi_hit_err_d = 1'b1;
          if (!retry_q && hit_count_q != CNT_MAX) hit_count_d = hit_count_q + CNT_ONE;
          state_d = IDLE;
        end else begin
          if (!retry_q && miss_count_q != CNT_MAX) miss_count_d = miss_count_q + CNT_ONE;
          victim_way_d = victim_sel;
          if (valid[victim_sel] && dirty[victim_sel]) begin
            if (wb_count_q != CNT_MAX) wb_count_d = wb_count_q + CNT_ONE;
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        if (bus.pmem_resp) state_d = request ? FILL : IDLE;
      end
      FILL: begin
        bus.pmem_read = 1'b1;
        // The fetched line is written even if the CPU has abandoned the request.
        if (bus.pmem_resp) begin
          way_load    = victim_onehot;
          data_sel    = 1'b1;
          dirty_clear = 1'b1;
          retry_d     = 1'b1;
          state_d     = request ? CHECK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      victim_way_q    <= 3'd0;
      retry_q         <= 1'b0;
      multi_hit_err_q <= 1'b0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
      wb_count_q      <= '0;
    end else begin
      state_q         <= state_d;
      victim_way_q    <= victim_way_d;
      retry_q         <= retry_d;
      multi_hit_err_q <= multi_hit_err_d;
      hit_count_q     <= hit_count_d;
      miss_count_q    <= miss_count_d;
      wb_count_q      <= wb_count_d;
    end
  end

  assign victim_way    = victim_way_q;
  assign multi_hit_err = multi_hit_err_q;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;
  assign wb_count      = wb_count_q;

endmodule

// File: tb/tb_cache_way_controller.sv
// Randomized scoreboard bench for cache_way_controller: a transaction-level model queues
// the expected per-cycle output events and an independent monitor compares them.
module tb_cache_way_controller;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic       mem_resp;
    logic       lru_update;
    logic [7:0] lru_hit;
    logic [7:0] way_load;
    logic       data_sel;
    logic       dirty_set;
    logic       dirty_clear;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_addr_sel;
    logic [2:0] victim_way;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    hit, valid, dirty;
  logic [2:0]    lru_way;
  logic          lru_update;
  logic [7:0]    lru_hit, way_load;
  logic          data_sel, dirty_set, dirty_clear;
  logic [2:0]    victim_way;
  logic          multi_hit_err;
  logic [CW-1:0] hit_count, miss_count, wb_count;

  cache_way_controller_if bus ();

  cache_way_controller #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .hit          (hit),
    .valid        (valid),
    .dirty        (dirty),
    .lru_way      (lru_way),
    .lru_update   (lru_update),
    .lru_hit      (lru_hit),
    .way_load     (way_load),
    .data_sel     (data_sel),
    .dirty_set    (dirty_set),
    .dirty_clear  (dirty_clear),
    .victim_way   (victim_way),
    .multi_hit_err(multi_hit_err),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .wb_count     (wb_count)
  );

  always #5 clk = ~clk;

  int         errors, checks;
  bit         mon_en;
  ev_t        exp_q[$];
  int         m_hits, m_misses, m_wbs;
  logic [2:0] m_victim;
  bit         m_multi;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  function automatic int sat_inc(input int c);
    return (c < CMAX) ? c + 1 : c;
  endfunction

  // A completed CPU access: the lowest set hit bit is reported, written on a store.
  function automatic void push_hit(input logic [7:0] h, input bit is_write);
    ev_t e;
    int  ones;
    logic [7:0] first;
    ones  = 0;
    first = 8'd0;
    for (int w = 0; w < 8; w++) begin
      if (h[w]) begin
        ones++;
        if (first == 8'd0) first[w] = 1'b1;
      end
    end
    if (ones > 1) m_multi = 1'b1;
    e            = '0;
    e.mem_resp   = 1'b1;
    e.lru_update = 1'b1;
    e.lru_hit    = first;
    e.way_load   = is_write ? first : 8'd0;
    e.dirty_set  = is_write;
    e.victim_way = m_victim;
    exp_q.push_back(e);
  endfunction

  task automatic applyStimulus(input bit is_write, input bit is_miss, input logic [7:0] hit_v,
                               input logic [7:0] valid_v, input logic [7:0] dirty_v,
                               input logic [2:0] lru_v, input bit drop_in_wb);
    ev_t        e;
    int         kw, kf, cnt, cycles;
    bit         wb, found, got_resp, next_resp, fill_done, wb_done, in_pmem;
    logic [2:0] v;
    logic [7:0] retry_hit;
    kw        = $urandom_range(2, 5);
    kf        = $urandom_range(2, 5);
    wb        = 1'b0;
    retry_hit = 8'd0;
    if (!is_miss) begin
      m_hits = sat_inc(m_hits);
      push_hit(hit_v, is_write);
    end else begin
      v     = lru_v;
      found = 1'b0;
      for (int w = 0; w < 8; w++) begin
        if (!found && !valid_v[w]) begin
          v     = 3'(w);
          found = 1'b1;
        end
      end
      wb       = valid_v[v] && dirty_v[v];
      m_misses = sat_inc(m_misses);
      m_victim = v;
      if (wb) begin
        m_wbs = sat_inc(m_wbs);
        for (int j = 0; j < kw; j++) begin
          e = '0;
          e.pmem_write    = 1'b1;
          e.pmem_addr_sel = 1'b1;
          e.victim_way    = v;
          exp_q.push_back(e);
        end
      end
      if (!(wb && drop_in_wb)) begin
        for (int j = 0; j < kf; j++) begin
          e = '0;
          e.pmem_read  = 1'b1;
          e.victim_way = v;
          if (j == kf - 1) begin
            e.way_load    = 8'd1 << v;
            e.data_sel    = 1'b1;
            e.dirty_clear = 1'b1;
          end
          exp_q.push_back(e);
        end
        retry_hit = 8'd1 << v;
        push_hit(retry_hit, is_write);
      end
    end

    bus.mem_read  = ~is_write;
    bus.mem_write = is_write;
    hit           = is_miss ? 8'd0 : hit_v;
    valid         = valid_v;
    dirty         = dirty_v;
    lru_way       = lru_v;
    cnt = 0; cycles = 0; next_resp = 0; got_resp = 0; fill_done = 0; wb_done = 0;
    forever begin
      @(negedge clk);
      in_pmem = 1'b0;
      if (bus.mem_resp) got_resp = 1'b1;
      if (bus.pmem_resp) begin
        fill_done = bus.pmem_read;
        wb_done   = bus.pmem_write;
        cnt       = 0;
        next_resp = 1'b0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        in_pmem   = 1'b1;
        cnt++;
        next_resp = (cnt == (bus.pmem_write ? kw : kf) - 1);
      end
      @(posedge clk); #1;
      cycles++;
      bus.pmem_resp = next_resp;
      if (got_resp || (drop_in_wb && wb && wb_done)) begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; hit = 8'd0;
        break;
      end
      if (fill_done) begin
        hit       = retry_hit;
        fill_done = 1'b0;
      end
      // Set state may change while memory is busy; only the latched victim matters.
      if (in_pmem) begin
        lru_way = 3'($urandom_range(0, 7));
        valid   = 8'($urandom);
        dirty   = 8'($urandom);
      end
      if (drop_in_wb && wb && in_pmem) begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      end
      if (cycles > 40) begin
        checks++; errors++;
        $display("[TB] FAIL transaction_timeout: got no completion after %0d cycles, required completion", cycles);
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0; hit = 8'd0;
        break;
      end
    end
  endtask

  task automatic checkOutput();
    @(negedge clk);
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
    check("wb_count", wb_count, m_wbs);
    check("victim_way", victim_way, m_victim);
    check("multi_hit_err", multi_hit_err, m_multi);
    check("events_pending", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  // Monitor: every cycle with any active controller output must match the next queued event.
  initial begin
    ev_t act, e;
    forever begin
      @(negedge clk);
      act.mem_resp      = bus.mem_resp;
      act.lru_update    = lru_update;
      act.lru_hit       = lru_hit;
      act.way_load      = way_load;
      act.data_sel      = data_sel;
      act.dirty_set     = dirty_set;
      act.dirty_clear   = dirty_clear;
      act.pmem_read     = bus.pmem_read;
      act.pmem_write    = bus.pmem_write;
      act.pmem_addr_sel = bus.pmem_addr_sel;
      act.victim_way    = victim_way;
      if (mon_en && (act.mem_resp || act.lru_update || act.lru_hit != 8'd0 || act.way_load != 8'd0 ||
                     act.data_sel || act.dirty_set || act.dirty_clear || act.pmem_read ||
                     act.pmem_write || act.pmem_addr_sel)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_event: got %h required no active outputs", act);
        end else begin
          e = exp_q.pop_front();
          check("output_event", act, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         w, miss, drop;
    logic [7:0] hv, vv, dv;
    int         waited;
    errors = 0; checks = 0; mon_en = 0;
    m_hits = 0; m_misses = 0; m_wbs = 0; m_victim = 3'd0; m_multi = 0;
    reset = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    hit = 8'd0; valid = 8'd0; dirty = 8'd0; lru_way = 3'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_mem_resp", bus.mem_resp, 0);
    check("reset_pmem_read", bus.pmem_read, 0);
    check("reset_pmem_write", bus.pmem_write, 0);
    check("reset_lru_update", lru_update, 0);
    check("reset_way_load", way_load, 0);
    check("reset_counters", {hit_count, miss_count, wb_count}, 0);
    mon_en = 1;
    @(posedge clk); #1;

    $display("[TB] directed hit, miss and write-back cases");
    applyStimulus(1'b0, 1'b0, 8'h04, 8'hFF, 8'h00, 3'd0, 1'b0); checkOutput();
    applyStimulus(1'b1, 1'b0, 8'h80, 8'hFF, 8'h00, 3'd0, 1'b0); checkOutput();
    applyStimulus(1'b0, 1'b1, 8'h00, 8'hF7, 8'h00, 3'd0, 1'b0); checkOutput();
    applyStimulus(1'b1, 1'b1, 8'h00, 8'hFF, 8'h20, 3'd5, 1'b0); checkOutput();
    applyStimulus(1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF, 3'd1, 1'b1); checkOutput();

    $display("[TB] randomized accesses");
    for (int n = 0; n < 220; n++) begin
      w    = 1'($urandom_range(0, 1));
      miss = ($urandom_range(0, 9) < 3);
      drop = ($urandom_range(0, 19) == 0);
      hv   = 8'd1 << $urandom_range(0, 7);
      vv   = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      dv   = 8'($urandom);
      applyStimulus(w, miss, hv, vv, dv, 3'($urandom_range(0, 7)), drop);
      checkOutput();
    end

    $display("[TB] multi-hit handling");
    applyStimulus(1'b0, 1'b0, 8'h12, 8'hFF, 8'h00, 3'd0, 1'b0); checkOutput();
    applyStimulus(1'b1, 1'b0, 8'h01, 8'hFF, 8'h00, 3'd0, 1'b0); checkOutput();

    $display("[TB] reset during line fill");
    mon_en = 0;
    bus.mem_read = 1'b1; hit = 8'd0; valid = 8'hF7; dirty = 8'd0; lru_way = 3'd0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.pmem_read && waited < 10);
    check("fill_started", bus.pmem_read, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; bus.mem_read = 1'b0;
    @(negedge clk);
    check("rst_fill_pmem_read", bus.pmem_read, 0);
    check("rst_fill_pmem_write", bus.pmem_write, 0);
    check("rst_fill_counters", {hit_count, miss_count, wb_count}, 0);
    check("rst_fill_victim", victim_way, 0);
    check("rst_fill_multi_hit_err", multi_hit_err, 0);
    @(posedge clk); #1 bus.pmem_resp = 1'b1;
    @(negedge clk);
    check("late_pmem_resp_way_load", way_load, 0);
    check("late_pmem_resp_dirty_clear", dirty_clear, 0);
    @(posedge clk); #1 bus.pmem_resp = 1'b0;
    m_hits = 0; m_misses = 0; m_wbs = 0; m_victim = 3'd0; m_multi = 0;
    exp_q.delete();
    mon_en = 1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 8'h40, 8'hFF, 8'h00, 3'd0, 1'b0); checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_way_controller.md
Name: cache_way_controller

Overview:
- Sequencing FSM for the 8-way set-associative, write-back LC3B cache datapath.
- Decides hit or miss from the tag-compare hit vector and selects a victim way.
- Drives write-back and line-fill transactions on the physical-memory port.
- Drives the LRU unit's update strobe and one-hot hit input exactly once per completed CPU access.
- Maintains saturating hit, miss and write-back performance counters.

Parameters:
CNT_WIDTH, 16, width of each performance counter.

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
mem_read  in  1  CPU read request; held until mem_resp
mem_write  in  1  CPU write request; held until mem_resp; has priority over mem_read
mem_resp  out  1  single-cycle CPU completion pulse
hit  in  8  one-hot tag-match vector for the current index; all zero = miss
valid  in  8  valid bits of the current set
dirty  in  8  dirty bits of the current set
lru_way  in  3  LRU unit's least-recently-used way for the current index
lru_update  out  1  LRU unit update strobe
lru_hit  out  8  one-hot way reported to the LRU unit; zero when lru_update=0
way_load  out  8  one-hot load enable for the tag, valid and data arrays
data_sel  out  1  array write source: 0 = CPU write merge, 1 = pmem line
dirty_set  out  1  set the dirty bit of the way_load way
dirty_clear  out  1  clear the dirty bit of the way_load way
victim_way  out  3  registered victim way
pmem_read  out  1  line-fill request
pmem_write  out  1  write-back request
pmem_resp  in  1  pmem completion
pmem_addr_sel  out  1  0 = {request tag, index}; 1 = {victim tag, index}
multi_hit_err  out  1  sticky flag: more than one hit bit seen
hit_count  out  CNT_WIDTH  first-try hits
miss_count  out  CNT_WIDTH  misses
wb_count  out  CNT_WIDTH  write-backs issued

Behaviour:
- States: IDLE, CHECK, WRITEBACK, FILL.
- Reset: state=IDLE; counters, victim_way, retry flag and multi_hit_err cleared to 0.
- Reset takes effect the cycle after it is sampled, including mid-WRITEBACK or mid-FILL. pmem_read/pmem_write drop immediately; the outstanding pmem_resp is ignored.
- Outputs not asserted by the current state are 0. Reset values of all outputs are 0.

IDLE:
- mem_read or mem_write sampled high -> CHECK, with retry=0.

CHECK (hit, hit != 0):
- mem_resp=1, lru_update=1, lru_hit = the hit way.
- If the request is a write: way_load = the hit way, data_sel=0, dirty_set=1.
- Next state IDLE. hit_count increments only when retry=0.
- More than one hit bit set: use the lowest-index set bit and set multi_hit_err.

CHECK (miss, hit == 0):
- No mem_resp. miss_count increments only when retry=0.
- Victim is the lowest-index way with valid=0; if all ways are valid, victim = lru_way. Latch it into victim_way.
- If the victim is valid and dirty: -> WRITEBACK, wb_count increments. Otherwise -> FILL.
- Victim selection uses the live valid/dirty/lru_way inputs only in this cycle. WRITEBACK and FILL use the registered victim_way.

WRITEBACK:
- pmem_write=1, pmem_addr_sel=1, held until pmem_resp.
- On pmem_resp -> FILL.

FILL:
- pmem_read=1, pmem_addr_sel=0, held until pmem_resp.
- On pmem_resp: way_load = one-hot(victim_way), data_sel=1, dirty_clear=1, retry=1, next state CHECK.
- The retry CHECK then hits and performs the normal hit actions, so the LRU is updated and write data merged exactly once per access.

Request handling:
- If mem_read and mem_write both drop during WRITEBACK or FILL, the pmem transaction still completes. The controller then returns to IDLE instead of CHECK and issues no mem_resp.
- Minimum hit latency: mem_resp in the cycle after the request is first sampled.
- Clean-miss latency: 2 cycles + fill latency. Dirty-miss latency: 2 cycles + write-back latency + fill latency.
- The CPU deasserts its request in the cycle mem_resp is seen; a request still high in IDLE starts a new access.

Counters:
- Each counter saturates at all-ones and never wraps.

Test Plan:
- Read hit: reset, then mem_read=1 with hit=8'h04 -> next cycle mem_resp=1, lru_update=1, lru_hit=8'h04, way_load=0; hit_count=1.
- Write hit: mem_write=1 with hit=8'h80 -> way_load=8'h80, data_sel=0, dirty_set=1, mem_resp=1, lru_hit=8'h80.
- Clean miss with an invalid way: hit=0, valid=8'hF7 -> victim_way=3, pmem_read until pmem_resp (3-cycle delay), then way_load=8'h08, data_sel=1, dirty_clear=1. Retry with hit=8'h08 gives mem_resp; miss_count=1, hit_count=0.
- Dirty miss on a full set: valid=8'hFF, dirty=8'h20, lru_way=5 -> WRITEBACK with pmem_write=1, pmem_addr_sel=1, wb_count=1. Changing lru_way to 2 mid-writeback does not change victim_way (stays 5); fill loads way_load=8'h20.
- Reset mid-FILL: reset=1 while pmem_read=1 -> next cycle pmem_read=0, state IDLE, all counters 0; a later pmem_resp produces no way_load.
- Counter saturation and multi-hit: preload hit_count to 16'hFFFF via repeated hits, then one more hit -> stays 16'hFFFF. Then hit=8'h12 -> lru_hit=8'h02, multi_hit_err=1 sticky until reset.
